// File: rtl/game_scheduler.sv
// Menu-driven game selector: picks one of NUM_GAMES games, holds the others in reset,
// forwards the shared buttons to the active game and muxes its value onto the display.
module game_scheduler #(
    parameter int NUM_GAMES   = 4,
    parameter int HOLD_CYCLES = 20_000_000,
    parameter int IDLE_CYCLES = 100_000_000,
    parameter int CTR_LEN     = 28
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [6:0]             btn,
    input  logic [4*NUM_GAMES-1:0] game_value,
    output logic [NUM_GAMES-1:0]   game_reset,
    output logic [6:0]             game_btn,
    output logic [3:0]             value,
    output logic [3:0]             active_game,
    output logic                   running
);

    typedef enum logic [1:0] {MENU, LAUNCH, RUN, EXIT} state_t;

    localparam logic [CTR_LEN-1:0]   HOLD_LAST = CTR_LEN'(HOLD_CYCLES - 1);
    localparam logic [CTR_LEN-1:0]   IDLE_LAST = CTR_LEN'(IDLE_CYCLES - 1);
    localparam logic [3:0]           LAST_SEL  = 4'(NUM_GAMES - 1);
    localparam logic [NUM_GAMES-1:0] ALL_RST   = '1;
    localparam logic [3:0]           VAL_OFF   = 4'd12;

    state_t               state;
    logic [3:0]           sel;
    logic [CTR_LEN-1:0]   hold_ctr;
    logic [CTR_LEN-1:0]   idle_ctr;
    logic [6:0]           btn_prev;
    logic [6:0]           rise;
    logic [3:0]           next_sel;
    logic [3:0]           sel_value;
    logic [NUM_GAMES-1:0] run_mask;
    logic                 exit_now;

    assign rise     = btn & ~btn_prev;
    assign next_sel = (sel == LAST_SEL) ? 4'd0 : sel + 4'd1;
    assign run_mask = ALL_RST & ~(NUM_GAMES'(1) << sel);
    assign exit_now = (btn[6] && hold_ctr == HOLD_LAST) || (idle_ctr == IDLE_LAST);

    always_comb begin
        sel_value = VAL_OFF;
        for (int i = 0; i < NUM_GAMES; i++) begin
            if (sel == 4'(i)) sel_value = game_value[4*i +: 4];
        end
    end

    // Outputs are registered for the state being entered, so they never lag the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= MENU;
            sel         <= 4'd0;
            value       <= VAL_OFF;
            game_reset  <= ALL_RST;
            game_btn    <= 7'd0;
            active_game <= 4'd0;
            running     <= 1'b0;
            hold_ctr    <= '0;
            idle_ctr    <= '0;
            btn_prev    <= 7'd0;
        end else begin
            btn_prev <= btn;
            case (state)
                MENU: begin
                    hold_ctr   <= '0;
                    idle_ctr   <= '0;
                    game_reset <= ALL_RST;
                    game_btn   <= 7'd0;
                    running    <= 1'b0;
                    if (rise[5]) begin
                        state       <= LAUNCH;
                        value       <= VAL_OFF;
                        active_game <= sel;
                    end else if (rise[4]) begin
                        sel         <= next_sel;
                        active_game <= next_sel;
                        value       <= next_sel + 4'd1;
                    end else begin
                        active_game <= sel;
                        value       <= sel + 4'd1;
                    end
                end
                LAUNCH: begin
                    hold_ctr    <= '0;
                    idle_ctr    <= '0;
                    game_btn    <= 7'd0;
                    active_game <= sel;
                    // Wait for every button to be released so the confirm press stays here.
                    if (btn == 7'd0) begin
                        state      <= RUN;
                        game_reset <= run_mask;
                        value      <= sel_value;
                        running    <= 1'b1;
                    end else begin
                        game_reset <= ALL_RST;
                        value      <= VAL_OFF;
                        running    <= 1'b0;
                    end
                end
                RUN: begin
                    active_game <= sel;
                    if (exit_now) begin
                        state      <= EXIT;
                        hold_ctr   <= '0;
                        idle_ctr   <= '0;
                        game_reset <= ALL_RST;
                        game_btn   <= 7'd0;
                        value      <= VAL_OFF;
                        running    <= 1'b0;
                    end else begin
                        hold_ctr   <= btn[6] ? hold_ctr + 1'b1 : '0;
                        idle_ctr   <= (btn != 7'd0) ? '0 : idle_ctr + 1'b1;
                        game_reset <= run_mask;
                        game_btn   <= {1'b0, btn[5:0]};
                        value      <= sel_value;
                        running    <= 1'b1;
                    end
                end
                EXIT: begin
                    hold_ctr    <= '0;
                    idle_ctr    <= '0;
                    game_reset  <= ALL_RST;
                    game_btn    <= 7'd0;
                    running     <= 1'b0;
                    active_game <= sel;
                    if (btn == 7'd0) begin
                        state <= MENU;
                        value <= sel + 4'd1;
                    end else begin
                        value <= VAL_OFF;
                    end
                end
                default: begin
                    state       <= MENU;
                    sel         <= 4'd0;
                    value       <= VAL_OFF;
                    game_reset  <= ALL_RST;
                    game_btn    <= 7'd0;
                    active_game <= 4'd0;
                    running     <= 1'b0;
                    hold_ctr    <= '0;
                    idle_ctr    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_scheduler.sv
// Bench for game_scheduler: directed scenarios then random button traffic, all checked
// cycle by cycle against a mode/selection reference model.
module tb_game_scheduler;

    localparam int N    = 3;
    localparam int HOLD = 8;
    localparam int IDLE = 20;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [6:0]     btn;
    logic [4*N-1:0] game_value;
    logic [N-1:0]   game_reset;
    logic [6:0]     game_btn;
    logic [3:0]     value;
    logic [3:0]     active_game;
    logic           running;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    game_scheduler #(
        .NUM_GAMES  (N),
        .HOLD_CYCLES(HOLD),
        .IDLE_CYCLES(IDLE),
        .CTR_LEN    (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn        (btn),
        .game_value (game_value),
        .game_reset (game_reset),
        .game_btn   (game_btn),
        .value      (value),
        .active_game(active_game),
        .running    (running)
    );

    // Reference model: mode 0=menu 1=launch 2=playing 3=leaving
    int         mode;
    int         m_sel;
    int         hold_len;
    int         quiet_len;
    logic [6:0] m_prev;
    logic [3:0]   e_value;
    logic [N-1:0] e_reset;
    logic [6:0]   e_gbtn;
    logic         e_run;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"},  16'(value),       16'(e_value));
        check({tag, ".reset"},  16'(game_reset),  16'(e_reset));
        check({tag, ".gbtn"},   16'(game_btn),    16'(e_gbtn));
        check({tag, ".run"},    16'(running),     16'(e_run));
        check({tag, ".active"}, 16'(active_game), 16'(m_sel));
    endtask

    task automatic model_reset();
        mode = 0; m_sel = 0; hold_len = 0; quiet_len = 0; m_prev = 7'd0;
        e_value = 4'd12; e_reset = '1; e_gbtn = 7'd0; e_run = 1'b0;
    endtask

    task automatic model_step(input logic [6:0] b, input logic [4*N-1:0] gv);
        logic [6:0] rise;
        rise = b & ~m_prev;
        case (mode)
            0: if (rise[5]) mode = 1;
               else if (rise[4]) m_sel = (m_sel + 1) % N;
            1: if (b == 0) begin mode = 2; hold_len = 0; quiet_len = 0; end
            2: if ((b[6] && hold_len == HOLD - 1) || quiet_len == IDLE - 1) mode = 3;
               else begin
                   hold_len  = b[6] ? hold_len + 1 : 0;
                   quiet_len = (b != 0) ? 0 : quiet_len + 1;
               end
            default: if (b == 0) mode = 0;
        endcase
        m_prev = b;
        e_reset = '1; e_gbtn = 7'd0; e_run = 1'b0; e_value = 4'd12;
        if (mode == 0) e_value = 4'(m_sel + 1);
        if (mode == 2) begin
            e_value = 4'((gv >> (4 * m_sel)) & 'hF);
            e_reset = '1 & ~(N'(1) << m_sel);
            e_gbtn  = b & 7'h3F;
            e_run   = 1'b1;
        end
    endtask

    task automatic step(input logic [6:0] b, input logic [4*N-1:0] gv, input string tag);
        @(negedge clk);
        btn = b;
        game_value = gv;
        @(posedge clk);
        model_step(b, gv);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [6:0] pat;
        int kind, len;
        reset_n = 1'b0;
        btn = 7'd0;
        game_value = '0;
        model_reset();
        #12;
        check("rst.value", 16'(value), 16'd12);
        check("rst.reset", 16'(game_reset), 16'h7);
        check("rst.gbtn",  16'(game_btn), 16'd0);
        check("rst.run",   16'(running), 16'd0);
        check("rst.active", 16'(active_game), 16'd0);
        @(negedge clk);
        reset_n = 1'b1;

        step(7'h00, 12'h000, "idle");
        check("menu.first", 16'(value), 16'd1);
        step(7'h00, 12'h000, "idle");

        for (int i = 0; i < 4; i++) begin
            step(7'h10, 12'h000, "btn5");
            step(7'h00, 12'h000, "btn5rel");
        end
        check("menu.wrap", 16'(value), 16'd2);
        for (int i = 0; i < 5; i++) step(7'h20, 12'h000, "launch_hold");
        check("launch.gbtn", 16'(game_btn), 16'd0);
        check("launch.run", 16'(running), 16'd0);
        step(7'h00, 12'h0D0, "enter_run");
        check("run.reset", 16'(game_reset), 16'h5);

        step(7'h00, 12'h0D0, "val13");
        check("run.val13", 16'(value), 16'd13);
        step(7'h01, 12'h0D0, "btn1");
        check("run.btn1", 16'(game_btn), 16'h01);
        step(7'h40, 12'h0D0, "btn7fwd");
        step(7'h00, 12'h0D0, "rel");

        for (int i = 0; i < 7; i++) step(7'h40, 12'h0A0, "hold7");
        step(7'h00, 12'h0A0, "hold7rel");
        check("hold7.run", 16'(running), 16'd1);
        for (int i = 0; i < 8; i++) step(7'h40, 12'h0A0, "hold8");
        check("hold8.run", 16'(running), 16'd0);
        check("hold8.reset", 16'(game_reset), 16'h7);
        step(7'h00, 12'h000, "back_menu");
        check("menu.same", 16'(value), 16'd2);

        step(7'h20, 12'h000, "launch2");
        step(7'h00, 12'h000, "run2");
        for (int i = 0; i < 14; i++) step(7'h00, 12'h050, "quiet");
        step(7'h02, 12'h050, "btn2");
        for (int i = 0; i < 19; i++) step(7'h00, 12'h050, "quiet2");
        check("idle19.run", 16'(running), 16'd1);
        step(7'h00, 12'h050, "quiet20");
        check("idle20.run", 16'(running), 16'd0);
        step(7'h00, 12'h050, "menu2");

        step(7'h20, 12'h000, "launch3");
        step(7'h00, 12'h000, "run3");
        step(7'h01, 12'h000, "play3");
        #1 reset_n = 1'b0;
        #1;
        check("arst.value", 16'(value), 16'd12);
        check("arst.reset", 16'(game_reset), 16'h7);
        check("arst.run", 16'(running), 16'd0);
        check("arst.gbtn", 16'(game_btn), 16'd0);
        model_reset();
        @(negedge clk);
        btn = 7'd0;
        reset_n = 1'b1;
        step(7'h00, 12'h000, "post_rst");
        step(7'h10, 12'h000, "sel1");
        step(7'h00, 12'h000, "sel1rel");
        step(7'h30, 12'h000, "both");
        check("both.value", 16'(value), 16'd12);
        check("both.active", 16'(active_game), 16'd1);
        step(7'h00, 12'h000, "both_run");

        for (int s = 0; s < 300; s++) begin
            kind = $urandom_range(0, 9);
            len = 1;
            pat = 7'd0;
            if (kind < 3) len = $urandom_range(1, 25);
            else if (kind == 3) begin pat = 7'h40; len = $urandom_range(1, 12); end
            else if (kind == 4) pat = 7'h10;
            else if (kind == 5) pat = 7'h20;
            else begin pat = 7'($urandom_range(0, 127)); len = $urandom_range(1, 4); end
            for (int c = 0; c < len; c++) step(pat, 12'($urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
